l2_interleave_splitter: RTL and testbench

//  Splits burst requests bound for the multi-channel L2/DRAM into per-channel sub-bursts.
//  No sub-burst crosses an interleave granule; each carries its channel index and compacted channel-local address.

---
 rtl/l2_interleave_splitter.sv | 93 +++++++++
 tb/tb_l2_interleave_splitter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_interleave_splitter.sv
// l2_interleave_splitter: splits bursts into per-channel sub-bursts that never cross an interleave granule
module l2_interleave_splitter #(
  parameter int AddrWidth     = 32,
  parameter int NumChannels   = 4,
  parameter int BeatBytes     = 64,
  parameter int MaxIleaveLog2 = 6,
  parameter int LenWidth      = 8,
  parameter int IdWidth       = 6,
  parameter int ChRegionLog2  = 28,
  localparam int ChBits  = $clog2(NumChannels),
  localparam int OffBits = $clog2(BeatBytes),
  localparam int GW      = $clog2(MaxIleaveLog2 + 1),
  localparam int RW      = LenWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [GW-1:0]        cfg_ileave_log2_i,
  input  logic                 cfg_linear_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 sub_valid_o,
  input  logic                 sub_ready_i,
  output logic [ChBits-1:0]    sub_ch_o,
  output logic [AddrWidth-1:0] sub_addr_o,
  output logic [LenWidth-1:0]  sub_len_o,
  output logic [IdWidth-1:0]   sub_id_o,
  output logic                 sub_last_o,
  output logic                 busy_o
);
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t               r_state, w_next;
  logic [AddrWidth-1:0] r_addr, w_off, w_to_bnd, w_il_addr, w_lin_addr;
  logic [RW-1:0]        r_rem, w_chunk;
  logic [IdWidth-1:0]   r_id;
  logic [GW-1:0]        r_g;
  logic                 r_linear, w_act, w_last;
  logic [7:0]           w_c;
  logic [ChBits-1:0]    w_ch;

  always_ff @(posedge clk_i)
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;

  always_comb
    w_next = (r_state == IDLE) ? (req_valid_i ? SPLIT : IDLE)
                               : ((sub_ready_i && w_last) ? IDLE : SPLIT);

  // w_c is the bit position of the channel field within the byte address
  always_comb begin
    w_c        = 8'(OffBits) + 8'(r_g);
    w_off      = (r_addr >> OffBits) & ((AddrWidth'(1) << r_g) - AddrWidth'(1));
    w_to_bnd   = (AddrWidth'(1) << r_g) - w_off;
    w_chunk    = (r_linear || AddrWidth'(r_rem) <= w_to_bnd) ? r_rem : RW'(w_to_bnd);
    w_last     = w_chunk == r_rem;
    w_ch       = r_linear ? r_addr[ChRegionLog2 +: ChBits] : ChBits'(r_addr >> w_c);
    w_il_addr  = ((r_addr >> (w_c + 8'(ChBits))) << w_c) | (r_addr & ((AddrWidth'(1) << w_c) - AddrWidth'(1)));
    w_lin_addr = r_addr & ~(AddrWidth'(NumChannels - 1) << ChRegionLog2);
  end

  // Outputs are forced low while reset is held, even before the first reset edge
  always_comb begin
    w_act       = rst_ni && r_state == SPLIT;
    req_ready_o = rst_ni && r_state == IDLE;
    sub_valid_o = w_act;
    busy_o      = w_act;
    sub_ch_o    = w_act ? w_ch : '0;
    sub_addr_o  = w_act ? (r_linear ? w_lin_addr : w_il_addr) : '0;
    sub_len_o   = w_act ? LenWidth'(w_chunk - RW'(1)) : '0;
    sub_id_o    = w_act ? r_id : '0;
    sub_last_o  = w_act && w_last;
  end

  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      r_addr   <= '0;
      r_rem    <= '0;
      r_id     <= '0;
      r_g      <= '0;
      r_linear <= 1'b0;
    end else if (req_valid_i && req_ready_o) begin
      r_addr   <= req_addr_i;
      r_rem    <= RW'(req_len_i) + RW'(1);
      r_id     <= req_id_i;
      r_g      <= (cfg_ileave_log2_i > GW'(MaxIleaveLog2)) ? GW'(MaxIleaveLog2) : cfg_ileave_log2_i;
      r_linear <= cfg_linear_i;
    end else if (sub_valid_o && sub_ready_i) begin
      r_addr   <= (r_addr & ~AddrWidth'(BeatBytes - 1)) + (AddrWidth'(w_chunk) << OffBits);
      r_rem    <= r_rem - w_chunk;
    end
endmodule

// File: tb/tb_l2_interleave_splitter.sv
// tb_l2_interleave_splitter: directed and randomized checks of the burst splitter against a byte-arithmetic model
module tb_l2_interleave_splitter;
  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [5:0]  id;
    logic        last;
  } sub_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg_g;
  logic        cfg_lin;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [5:0]  req_id;
  logic        sub_valid, sub_ready;
  logic [1:0]  sub_ch;
  logic [31:0] sub_addr;
  logic [7:0]  sub_len;
  logic [5:0]  sub_id;
  logic        sub_last, busy;

  int   total = 0;
  int   bad = 0;
  sub_t exp_q[$];

  always #5 clk = ~clk;

  l2_interleave_splitter dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_ileave_log2_i(cfg_g), .cfg_linear_i(cfg_lin),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_id_i(req_id), .sub_valid_o(sub_valid), .sub_ready_i(sub_ready),
    .sub_ch_o(sub_ch), .sub_addr_o(sub_addr), .sub_len_o(sub_len), .sub_id_o(sub_id),
    .sub_last_o(sub_last), .busy_o(busy)
  );

  function automatic sub_t cur();
    return sub_t'{sub_ch, sub_addr, sub_len, sub_id, sub_last};
  endfunction

  // Reference: channel = granule index mod channels, local = granule index / channels
  function automatic void model(input logic [31:0] a, input int len, input int id, input int g, input bit lin);
    longint unsigned addr = 64'(a);
    longint unsigned gbytes, ch, loc;
    int rem = len + 1;
    int gc = (g > 6) ? 6 : g;
    int chunk;
    sub_t e;
    while (rem > 0) begin
      if (lin) begin
        chunk = rem;
        ch = (addr >> 28) % 4;
        loc = addr & ~64'h3000_0000;
      end else begin
        gbytes = 64 * (64'd1 << gc);
        chunk = (1 << gc) - int'((addr / 64) % (64'd1 << gc));
        if (chunk > rem) chunk = rem;
        ch = (addr / gbytes) % 4;
        loc = (addr / (gbytes * 4)) * gbytes + addr % gbytes;
      end
      e.ch = 2'(ch); e.addr = 32'(loc); e.len = 8'(chunk - 1); e.id = 6'(id); e.last = (chunk == rem);
      exp_q.push_back(e);
      addr = ((addr / 64) * 64 + 64'(chunk) * 64) % 64'h1_0000_0000;
      rem -= chunk;
    end
  endfunction

  task automatic send(input logic [31:0] a, input int len, input int id, input int g, input bit lin);
    cfg_g = 3'(g); cfg_lin = lin; req_addr = a; req_len = 8'(len); req_id = 6'(id); req_valid = 1'b1;
    total++;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bad++;
    $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
    req_valid = 1'b0;
  endtask

  task automatic get_sub(output sub_t s, output int waited, input bit rnd);
    s = '0;
    for (int i = 0; i < 2000; i++) begin
      sub_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
      if (sub_valid && sub_ready) begin
        s = cur();
        waited = i;
        @(posedge clk); @(negedge clk);
        return;
      end
      @(posedge clk); @(negedge clk);
    end
    waited = -1;
    total++; bad++;
    $display("FAIL sub_timeout: sub_valid=%b required 1", sub_valid);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, sub_valid, busy, sub_addr, sub_len, sub_ch, sub_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b addr=%h required all 0", req_ready, sub_valid, busy, sub_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_boundary();
    sub_t s; int w;
    send(32'h8000_0300, 15, 5, 4, 0);
    total++;
    if (sub_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL latency: valid=%b busy=%b ready=%b required 1 1 0", sub_valid, busy, req_ready);
    end
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd5, 1'b0}) begin
      bad++; $display("FAIL boundary_sub0: got %h required %h", s, sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd5, 1'b0});
    end
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd5, 1'b1}) begin
      bad++; $display("FAIL boundary_sub1: got %h required %h", s, sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd5, 1'b1});
    end
    total++;
    if (sub_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL boundary_idle: valid=%b busy=%b ready=%b required 0 0 1", sub_valid, busy, req_ready);
    end
  endtask

  task automatic test_channel_wrap();
    sub_t s; int w;
    send(32'h8000_0C00, 31, 12, 4, 0);
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd3, 32'h2000_0000, 8'd15, 6'd12, 1'b0}) begin
      bad++; $display("FAIL wrap_sub0: got %h required %h", s, sub_t'{2'd3, 32'h2000_0000, 8'd15, 6'd12, 1'b0});
    end
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd0, 32'h2000_0400, 8'd15, 6'd12, 1'b1}) begin
      bad++; $display("FAIL wrap_sub1: got %h required %h", s, sub_t'{2'd0, 32'h2000_0400, 8'd15, 6'd12, 1'b1});
    end
    total++;
    if (w !== 0) begin
      bad++; $display("FAIL throughput: sub1 waited %0d cycles required 0", w);
    end
  endtask

  task automatic test_backpressure();
    sub_t s, snap; int w;
    sub_ready = 1'b0;
    send(32'h8000_0300, 15, 7, 4, 0);
    snap = cur();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (cur() !== snap || req_ready !== 1'b0 || sub_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold cycle %0d: got %h ready=%b required %h ready=0", i, cur(), req_ready, snap);
      end
    end
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd7, 1'b0}) begin
      bad++; $display("FAIL bp_sub0: got %h required %h", s, sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd7, 1'b0});
    end
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd7, 1'b1}) begin
      bad++; $display("FAIL bp_sub1: got %h required %h", s, sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd7, 1'b1});
    end
  endtask

  task automatic test_linear_cfg();
    sub_t s; int w;
    send(32'h1800_0040, 7, 9, 4, 1);
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd1, 32'h0800_0040, 8'd7, 6'd9, 1'b1}) begin
      bad++; $display("FAIL linear_sub: got %h required %h", s, sub_t'{2'd1, 32'h0800_0040, 8'd7, 6'd9, 1'b1});
    end
    send(32'h8000_0300, 15, 3, 4, 0);
    cfg_g = 3'd2; cfg_lin = 1'b1;
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd3, 1'b0}) begin
      bad++; $display("FAIL cfgchg_sub0: got %h required %h", s, sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd3, 1'b0});
    end
    cfg_g = 3'd0;
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd3, 1'b1}) begin
      bad++; $display("FAIL cfgchg_sub1: got %h required %h", s, sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd3, 1'b1});
    end
    cfg_g = 3'd4; cfg_lin = 1'b0;
  endtask

  task automatic test_reset_mid();
    sub_t s; int w;
    send(32'h8000_0C00, 31, 1, 4, 0);
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd3, 32'h2000_0000, 8'd15, 6'd1, 1'b0}) begin
      bad++; $display("FAIL rstmid_sub0: got %h required %h", s, sub_t'{2'd3, 32'h2000_0000, 8'd15, 6'd1, 1'b0});
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (sub_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_hold: valid=%b busy=%b ready=%b required 0 0 0", sub_valid, busy, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (sub_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_drop: valid=%b ready=%b required 0 1", sub_valid, req_ready);
    end
    send(32'h8000_0300, 15, 2, 4, 0);
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd2, 1'b0}) begin
      bad++; $display("FAIL rstmid_new0: got %h required %h", s, sub_t'{2'd0, 32'h2000_0300, 8'd3, 6'd2, 1'b0});
    end
    get_sub(s, w, 0);
    total++;
    if (s !== sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd2, 1'b1}) begin
      bad++; $display("FAIL rstmid_new1: got %h required %h", s, sub_t'{2'd1, 32'h2000_0000, 8'd11, 6'd2, 1'b1});
    end
  endtask

  task automatic test_random();
    sub_t s, e; int w, len, g, id, n;
    logic [31:0] a;
    bit lin;
    for (int t = 0; t < 60; t++) begin
      a   = $urandom;
      len = ($urandom % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      g   = int'($urandom % 8);
      lin = ($urandom % 4 == 0);
      id  = int'($urandom % 64);
      exp_q.delete();
      model(a, len, id, g, lin);
      send(a, len, id, g, lin);
      n = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        get_sub(s, w, 1);
        total++;
        if (s !== e) begin
          bad++;
          $display("FAIL rand_sub t=%0d n=%0d addr=%h len=%0d g=%0d lin=%b: got %h required %h", t, n, a, len, g, lin, s, e);
        end
        n++;
      end
      total++;
      if (sub_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL rand_end t=%0d: valid=%b ready=%b required 0 1", t, sub_valid, req_ready);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_g = 3'd4; cfg_lin = 1'b0; req_valid = 1'b0;
    req_addr = '0; req_len = '0; req_id = '0; sub_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_boundary();
    test_channel_wrap();
    test_backpressure();
    test_linear_cfg();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
